bp_clint_timer_slice: RTL
=========================

// Module: bp_clint_timer_slice
//
// PURPOSE
//  Per-core CLINT register slice: holds msip, mtimecmp and mtime and drives the machine software
//  and timer interrupt lines into the core. Sits downstream of the I/O address decode, which
//  forwards CLINT-range accesses to it. Accesses use a valid/ready request channel and a
//  valid/yumi response channel. mtime advances on rising edges of an asynchronous RTC input.
//
// PARAMETERS
//  rtc_sync_stages_p  2    flops in the rtc_i synchronizer (>=2)
//  mtime_width_p      64   width of mtime/mtimecmp; data bus is always 64b
//
// PORTS
//  clk_i            in   1    core clock
//  reset_n_i        in   1    reset, asynchronous assert, active-low
//  rtc_i            in   1    raw real-time-clock tick, asynchronous to clk_i
//  req_v_i          in   1    request valid
//  req_ready_and_o  out  1    request accepted when req_v_i & req_ready_and_o
//  req_w_i          in   1    1=write, 0=read
//  req_addr_i       in   16   byte offset within the CLINT window
//  req_data_i       in   64   write data
//  resp_v_o         out  1    response valid
//  resp_yumi_i      in   1    response consumed; legal only when resp_v_o
//  resp_data_o      out  64   read data; 0 for writes
//  software_irq_o   out  1    msip[0]
//  timer_irq_o      out  1    mtime >= mtimecmp
//
// BEHAVIOUR
//  Reset (reset_n_i=0, async): mtime=0, mtimecmp=all-ones, msip=0, sync chain=0, resp buffer
//   empty. Outputs: resp_v_o=0, resp_data_o=0, req_ready_and_o=0 while reset asserted,
//   software_irq_o=0, timer_irq_o=0. Reset mid-transaction drops the buffered response.
//  Address map (16b offset, full compare): 0x0000 msip (only bit0 writable, others read 0),
//   0x4000 mtimecmp, 0xBFF8 mtime. Any other offset: read returns 0, write ignored, a response
//   is still issued.
//  Handshake: one-entry response buffer, states EMPTY/FULL.
//   - EMPTY: req_ready_and_o=1. On accept: perform read/write and go to FULL. resp_v_o goes
//     high the next cycle (1-cycle latency).
//   - FULL: resp_v_o=1, req_ready_and_o=0. On resp_yumi_i: go to EMPTY. There is no same-cycle
//     pass-through, so back-to-back throughput is one access per 2 cycles.
//   - resp_data_o is stable while resp_v_o=1. It holds the register value sampled in the
//     accept cycle, before that cycle's tick or write is applied.
//  RTC: rtc_i passes through rtc_sync_stages_p flops. A tick is a 0->1 transition of the
//   synchronized value. Each tick does mtime += 1, with modulo-2^mtime_width_p wrap
//   (all-ones -> 0). A constant-high rtc_i gives exactly one tick.
//  Simultaneous events: a write to mtime in the same cycle as a tick wins. The new value is
//   loaded and the tick is lost.
//  Interrupts: registered outputs, updated the cycle after mtime/mtimecmp/msip change.
//   - timer_irq_o = (mtime >= mtimecmp), unsigned compare.
//   - software_irq_o = msip[0].
//  mtime_width_p < 64: reads zero-extend; writes use the low bits.
//
// TESTING
//  1 reset: drive reset_n_i low mid-response -> resp_v_o=0, timer_irq_o=0, read 0x4000 after
//    release returns 64'hFFFF_FFFF_FFFF_FFFF.
//  2 msip: write 0x0000 with 64'h3 -> software_irq_o=1 two cycles after accept; read returns 64'h1.
//  3 timer: write mtimecmp=5, then pulse rtc_i 5 times -> timer_irq_o rises the cycle after
//    mtime hits 5; writing mtimecmp=6 clears it.
//  4 wrap/collision: write mtime=64'hFFFF_FFFF_FFFF_FFFF, tick -> mtime reads 0. Write mtime=100
//    in the same cycle as a tick -> reads 100.
//  5 handshake: hold resp_yumi_i=0 for 10 cycles -> req_ready_and_o=0 and resp_data_o stable.
//    Issue 4 back-to-back requests with constant yumi -> accepts exactly every 2nd cycle.
//  6 unmapped: read 0x1234 -> resp_data_o=0. Write 0x1234 -> msip/mtime/mtimecmp unchanged.

Source files
------------

// File: rtl/bp_clint_timer_slice.sv
// Per-core CLINT slice: msip/mtimecmp/mtime registers behind a valid/ready request and
// valid/yumi response channel, with mtime clocked by a synchronized RTC tick.
module bp_clint_timer_slice #(
  parameter int rtc_sync_stages_p = 2,
  parameter int mtime_width_p     = 64
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        rtc_i,
  input  logic        req_v_i,
  output logic        req_ready_and_o,
  input  logic        req_w_i,
  input  logic [15:0] req_addr_i,
  input  logic [63:0] req_data_i,
  output logic        resp_v_o,
  input  logic        resp_yumi_i,
  output logic [63:0] resp_data_o,
  output logic        software_irq_o,
  output logic        timer_irq_o
);

  localparam int W = mtime_width_p;

  typedef enum logic {ST_EMPTY, ST_FULL} state_e;

  state_e                       state_q, state_d;
  logic [rtc_sync_stages_p-1:0] sync_q;
  logic                         rtc_prev_q;
  logic                         tick;
  logic [W-1:0]                 mtime_q, mtime_d;
  logic [W-1:0]                 mtimecmp_q, mtimecmp_d;
  logic                         msip_q, msip_d;
  logic [63:0]                  resp_data_q, resp_data_d;
  logic [63:0]                  rdata;
  logic                         timer_irq_q, sw_irq_q;
  logic                         accept;
  logic                         hit_msip, hit_cmp, hit_mtime;

  assign tick = sync_q[rtc_sync_stages_p-1] & ~rtc_prev_q;

  assign hit_msip  = (req_addr_i == 16'h0000);
  assign hit_cmp   = (req_addr_i == 16'h4000);
  assign hit_mtime = (req_addr_i == 16'hBFF8);

  // Ready is forced low while reset is held even though the FSM already sits in EMPTY.
  assign req_ready_and_o = (state_q == ST_EMPTY) & reset_n_i;
  assign accept          = req_v_i & req_ready_and_o;
  assign resp_v_o        = (state_q == ST_FULL);
  assign resp_data_o     = resp_data_q;
  assign software_irq_o  = sw_irq_q;
  assign timer_irq_o     = timer_irq_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept)      state_d = ST_FULL;
      ST_FULL:  if (resp_yumi_i) state_d = ST_EMPTY;
      default:                   state_d = ST_EMPTY;
    endcase
  end

  // Read mux zero-extends the narrower timer registers onto the 64b bus.
  always_comb begin
    rdata = '0;
    if (hit_msip)       rdata[0]     = msip_q;
    else if (hit_cmp)   rdata[W-1:0] = mtimecmp_q;
    else if (hit_mtime) rdata[W-1:0] = mtime_q;
  end

  always_comb begin
    resp_data_d = resp_data_q;
    if (accept) resp_data_d = req_w_i ? 64'h0 : rdata;
  end

  // A write to mtime outranks a coincident tick; the tick is dropped.
  always_comb begin
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    mtime_d    = tick ? mtime_q + 1'b1 : mtime_q;
    if (accept && req_w_i) begin
      if (hit_msip)  msip_d     = req_data_i[0];
      if (hit_cmp)   mtimecmp_d = req_data_i[W-1:0];
      if (hit_mtime) mtime_d    = req_data_i[W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_EMPTY;
      sync_q      <= '0;
      rtc_prev_q  <= 1'b0;
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      msip_q      <= 1'b0;
      resp_data_q <= '0;
      timer_irq_q <= 1'b0;
      sw_irq_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[rtc_sync_stages_p-2:0], rtc_i};
      rtc_prev_q  <= sync_q[rtc_sync_stages_p-1];
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      resp_data_q <= resp_data_d;
      timer_irq_q <= (mtime_q >= mtimecmp_q);
      sw_irq_q    <= msip_q;
    end
  end

endmodule
